// File: rtl/matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matmul_seq_ctrl
// Brief    : 2x2 matrix product C = A x B sequenced through one shared
//            external multiplier; results commit together on completion.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_seq_ctrl #(
    parameter int DW      = 4,
    parameter int PW      = 8,
    parameter int MUL_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    input  logic [2:0]    ld_idx,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] mul_a,
    output logic [DW-1:0] mul_b,
    input  logic [PW-1:0] mul_p,
    input  logic [1:0]    c_sel,
    output logic [PW:0]   c_out,
    output logic          c_valid
);

    localparam int c_WAIT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'((MUL_LAT > 0) ? MUL_LAT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [2:0]            r_term;
    logic [c_WAIT_W-1:0]   r_wait;
    logic [DW-1:0]         r_a [4];
    logic [DW-1:0]         r_b [4];
    logic [PW:0]           r_acc;
    logic [PW:0]           r_stage [3];
    logic [PW:0]           r_res [4];
    logic                  r_busy;
    logic                  r_done;
    logic                  r_c_valid;
    logic [DW-1:0]         r_mul_a;
    logic [DW-1:0]         r_mul_b;

    logic [2:0]            w_nt;
    logic [DW-1:0]         w_nxt_a;
    logic [DW-1:0]         w_nxt_b;
    logic [DW-1:0]         w_a00;
    logic [DW-1:0]         w_b00;
    logic [PW:0]           w_sum;
    logic                  w_capture;

    // Term index bits are {row i, col j, inner k}: operands A[i][k] and B[k][j].
    assign w_nt      = r_term + 3'd1;
    assign w_nxt_a   = r_a[{w_nt[2], w_nt[0]}];
    assign w_nxt_b   = r_b[{w_nt[0], w_nt[1]}];
    assign w_a00     = (ld_valid && ld_idx == 3'd0) ? ld_data : r_a[0];
    assign w_b00     = (ld_valid && ld_idx == 3'd4) ? ld_data : r_b[0];
    assign w_sum     = r_acc + {1'b0, mul_p};
    assign w_capture = ((r_state == S_ISSUE) && (MUL_LAT == 0)) ||
                       ((r_state == S_WAIT) && (r_wait == c_WAIT_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_term    <= '0;
            r_wait    <= '0;
            r_acc     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_c_valid <= 1'b0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_res[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ld_valid) begin
                        if (ld_idx[2]) r_b[ld_idx[1:0]] <= ld_data;
                        else           r_a[ld_idx[1:0]] <= ld_data;
                        r_c_valid <= 1'b0;
                    end
                    // Term 0 operands bypass a same-cycle load of A00/B00.
                    if (start) begin
                        r_state <= S_ISSUE;
                        r_term  <= '0;
                        r_busy  <= 1'b1;
                        r_mul_a <= w_a00;
                        r_mul_b <= w_b00;
                    end
                end
                S_ISSUE: begin
                    if (MUL_LAT != 0) begin
                        r_state <= S_WAIT;
                        r_wait  <= '0;
                    end
                end
                S_WAIT: begin
                    r_wait <= r_wait + 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_capture) begin
                if (!r_term[0]) begin
                    r_acc <= {1'b0, mul_p};
                end else begin
                    case (r_term[2:1])
                        2'd0: r_stage[0] <= w_sum;
                        2'd1: r_stage[1] <= w_sum;
                        2'd2: r_stage[2] <= w_sum;
                        default: begin
                            r_res[0] <= r_stage[0];
                            r_res[1] <= r_stage[1];
                            r_res[2] <= r_stage[2];
                            r_res[3] <= w_sum;
                        end
                    endcase
                end
                if (r_term == 3'd7) begin
                    r_state   <= S_DONE;
                    r_done    <= 1'b1;
                    r_c_valid <= 1'b1;
                    r_mul_a   <= '0;
                    r_mul_b   <= '0;
                end else begin
                    r_term  <= w_nt;
                    r_state <= S_ISSUE;
                    r_mul_a <= w_nxt_a;
                    r_mul_b <= w_nxt_b;
                end
            end
        end
    end

    assign ld_ready = (r_state == S_IDLE);
    assign busy     = r_busy;
    assign done     = r_done;
    assign c_valid  = r_c_valid;
    assign mul_a    = r_mul_a;
    assign mul_b    = r_mul_b;
    assign c_out    = r_res[c_sel];

endmodule
`default_nettype wire

// File: tb/tb_matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_seq_ctrl
// Brief    : Self-checking bench for matmul_seq_ctrl at MUL_LAT 0 and 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_seq_ctrl;

    localparam int DW = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic [2:0]    ld_idx;
    logic [DW-1:0] ld_data;
    logic          start;
    logic [1:0]    c_sel;

    logic          ld_ready0, busy0, done0, c_valid0;
    logic [DW-1:0] mul_a0, mul_b0;
    logic [PW-1:0] mul_p0;
    logic [PW:0]   c_out0;
    logic          ld_ready2, busy2, done2, c_valid2;
    logic [DW-1:0] mul_a2, mul_b2;
    logic [PW-1:0] mul_p2;
    logic [PW:0]   c_out2;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign mul_p0 = {4'b0, mul_a0} * {4'b0, mul_b0};
    assign mul_p2 = {4'b0, mul_a2} * {4'b0, mul_b2};

    matmul_seq_ctrl #(.DW(DW), .PW(PW), .MUL_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data),
        .ld_ready(ld_ready0), .start(start), .busy(busy0), .done(done0),
        .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0), .c_sel(c_sel),
        .c_out(c_out0), .c_valid(c_valid0)
    );

    matmul_seq_ctrl #(.DW(DW), .PW(PW), .MUL_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data),
        .ld_ready(ld_ready2), .start(start), .busy(busy2), .done(done2),
        .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2), .c_sel(c_sel),
        .c_out(c_out2), .c_valid(c_valid2)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: operand memories, matrix product, and a cycle phase
    // counter k (1..N while busy, N = 8*(1+lat)+1, done in phase N).
    int          TA [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int          TB [8] = '{0, 2, 1, 3, 0, 2, 1, 3};
    int unsigned ma [2][4];
    int unsigned mb [2][4];
    int unsigned mc [2][4];
    bit          mcv [2];
    int          k [2];

    function automatic int lat(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic int nlen(input int d);
        return 8 * (1 + lat(d)) + 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                k[d]   <= 0;
                mcv[d] <= 1'b0;
                for (int i = 0; i < 4; i++) begin
                    ma[d][i] <= 0;
                    mb[d][i] <= 0;
                    mc[d][i] <= 0;
                end
            end else if (k[d] == 0) begin
                if (ld_valid) begin
                    if (ld_idx < 3'd4) ma[d][ld_idx[1:0]] <= ld_data;
                    else               mb[d][ld_idx[1:0]] <= ld_data;
                    mcv[d] <= 1'b0;
                end
                if (start) k[d] <= 1;
            end else if (k[d] == nlen(d)) begin
                k[d] <= 0;
            end else begin
                k[d] <= k[d] + 1;
                if (k[d] + 1 == nlen(d)) begin
                    for (int i = 0; i < 2; i++)
                        for (int j = 0; j < 2; j++)
                            mc[d][2*i+j] <= ma[d][2*i] * mb[d][j] + ma[d][2*i+1] * mb[d][2+j];
                    mcv[d] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                int unsigned ea, eb;
                bit eb_busy;
                eb_busy = (k[d] != 0);
                ea = 0;
                eb = 0;
                if (k[d] >= 1 && k[d] < nlen(d)) begin
                    ea = ma[d][TA[(k[d]-1) / (1 + lat(d))]];
                    eb = mb[d][TB[(k[d]-1) / (1 + lat(d))]];
                end
                chk($sformatf("busy[%0d]", d),     (d == 0) ? busy0 : busy2, eb_busy);
                chk($sformatf("done[%0d]", d),     (d == 0) ? done0 : done2, k[d] == nlen(d));
                chk($sformatf("ld_ready[%0d]", d), (d == 0) ? ld_ready0 : ld_ready2, !eb_busy);
                chk($sformatf("mul_a[%0d]", d),    (d == 0) ? mul_a0 : mul_a2, ea);
                chk($sformatf("mul_b[%0d]", d),    (d == 0) ? mul_b0 : mul_b2, eb);
                chk($sformatf("c_valid[%0d]", d),  (d == 0) ? c_valid0 : c_valid2, mcv[d]);
                chk($sformatf("c_out[%0d]", d),    (d == 0) ? c_out0 : c_out2, mc[d][c_sel]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int idx, input int val);
        ld_valid = 1'b1;
        ld_idx   = 3'(idx);
        ld_data  = DW'(val);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic load_all(input int v0, input int v1, input int v2, input int v3,
                            input int v4, input int v5, input int v6, input int v7);
        load(0, v0); load(1, v1); load(2, v2); load(3, v3);
        load(4, v4); load(5, v5); load(6, v6); load(7, v7);
    endtask

    // Starts a computation and watches 40 cycles; optional load alongside
    // start, optional load+start injection while busy.
    task automatic run(input bit inj, input bit ld_with, input int idx, input int dat);
        int b0, b2, d0, d2;
        b0 = 0; b2 = 0; d0 = 0; d2 = 0;
        start = 1'b1;
        if (ld_with) begin
            ld_valid = 1'b1;
            ld_idx   = 3'(idx);
            ld_data  = DW'(dat);
        end
        tick();
        start    = 1'b0;
        ld_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy0) b0++;
            if (busy2) b2++;
            if (done0) d0 = c;
            if (done2) d2 = c;
            @(posedge clk);
            #2;
            if (inj && c == 3) begin
                ld_valid = 1'b1;
                ld_idx   = 3'd0;
                ld_data  = 4'd9;
                start    = 1'b1;
            end else begin
                ld_valid = 1'b0;
                start    = 1'b0;
            end
        end
        chk("busy_len0", b0, 9);
        chk("busy_len2", b2, 25);
        chk("done_pos0", d0, 9);
        chk("done_pos2", d2, 25);
    endtask

    task automatic chk_c(input int sel, input int exp);
        c_sel = 2'(sel);
        #1;
        chk($sformatf("c_out0_sel%0d", sel), c_out0, exp);
        chk($sformatf("c_out2_sel%0d", sel), c_out2, exp);
    endtask

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_idx = '0; ld_data = '0; start = 1'b0; c_sel = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_busy0", busy0, 0);
        chk("rst_c_valid0", c_valid0, 0);
        chk("rst_c_out0", c_out0, 0);
        chk("rst_ld_ready0", ld_ready0, 1);
        tick();

        // A=[1,2;3,4], B=[5,6;7,1]
        load_all(1, 2, 3, 4, 5, 6, 7, 1);
        run(1'b0, 1'b0, 0, 0);
        chk_c(0, 19); chk_c(1, 8); chk_c(2, 43); chk_c(3, 22);
        chk("c_valid0_s1", c_valid0, 1);
        chk("c_valid2_s1", c_valid2, 1);

        // Load and second start while busy must be ignored.
        run(1'b1, 1'b0, 0, 0);
        chk_c(0, 19); chk_c(3, 22);

        // Post-done load drops c_valid but keeps results.
        load(5, 3);
        chk("c_valid0_ld", c_valid0, 0);
        chk("c_valid2_ld", c_valid2, 0);
        chk_c(1, 8);
        // Same-cycle load B00=2 with start: B=[2,3;7,1].
        run(1'b0, 1'b1, 4, 2);
        chk_c(0, 16); chk_c(1, 5); chk_c(2, 34); chk_c(3, 13);

        // Abort during term 3 of the MUL_LAT=0 instance.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("term3_mul_a0", mul_a0, 2);
        chk("term3_mul_b0", mul_b0, 1);
        rst = 1'b1;
        #1;
        chk("abort_busy0", busy0, 0);
        chk("abort_done0", done0, 0);
        chk("abort_c_valid0", c_valid0, 0);
        chk("abort_mul_a0", mul_a0, 0);
        chk("abort_mul_b0", mul_b0, 0);
        chk("abort_c_out0", c_out0, 0);
        chk("abort_busy2", busy2, 0);
        chk("abort_c_valid2", c_valid2, 0);
        tick();
        rst = 1'b0;
        tick();

        // Full-scale operands: every result 2*15*15 = 450.
        load_all(15, 15, 15, 15, 15, 15, 15, 15);
        run(1'b0, 1'b0, 0, 0);
        chk_c(0, 450); chk_c(1, 450); chk_c(2, 450); chk_c(3, 450);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
